pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 16 +
 rtl/pipe_skid_reg_if.sv | 24 ++
 rtl/pipe_skid_reg_flopenr.sv | 19 +
 rtl/pipe_skid_reg.sv | 97 +++++++++
 tb/tb_pipe_skid_reg.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the pipe_skid_reg elastic register slice.
package pipe_pkg;

  localparam int WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg; master drives upstream data and downstream ready.
interface pipe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int N = WIDTH_DEF
);
  logic [N-1:0] d;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] q;
  logic         q_valid;
  logic         out_ready;
  logic         flush;

  modport master (
    output d, in_valid, out_ready, flush,
    input  in_ready, q, q_valid
  );

  modport slave (
    input  d, in_valid, out_ready, flush,
    output in_ready, q, q_valid
  );
endinterface

// File: rtl/pipe_skid_reg_flopenr.sv
// N-bit enabled register with synchronous active-low reset and synchronous clear.
module flopenr #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!reset)      q_o <= '0;
    else if (clr_i)  q_o <= '0;
    else if (en_i)   q_o <= d_i;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic register (main + skid) with registered valid/ready on both sides.
// Optional macro PIPE_SKID_STATS_EN adds a saturating downstream-stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int N = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pipe_skid_reg_if.slave bus
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]   stall_count
`endif
);

  state_t       state_q, state_d;
  logic         main_en, skid_en, main_from_skid;
  logic [N-1:0] main_d, main_q, skid_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Handshake outputs come only from state_q so no input reaches them combinationally.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          main_en = 1'b1;
        end
      end
      BUSY: begin
        if (bus.in_valid && bus.out_ready) begin
          main_en = 1'b1;
        end else if (bus.in_valid) begin
          state_d = FULL;
          skid_en = 1'b1;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d        = BUSY;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end

  assign main_d = main_from_skid ? skid_q : bus.d;

  flopenr #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.flush),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  flopenr #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.flush),
    .en_i  (skid_en),
    .d_i   (bus.d),
    .q_o   (skid_q)
  );

  assign bus.q        = main_q;
  assign bus.q_valid  = (state_q != EMPTY);
  assign bus.in_ready = (state_q != FULL);

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_q;

  // Flush deliberately leaves the statistic untouched.
  always_ff @(posedge clk) begin
    if (!reset)                              stall_q <= '0;
    else if (bus.q_valid && !bus.out_ready)  stall_q <= sat_inc32(stall_q);
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: queue-level reference model plus literal checkpoints.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_skid_reg_if #(.N(N)) bus ();

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_count;
  pipe_skid_reg #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus), .stall_count(stall_count));
`else
  pipe_skid_reg #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of at most two held words; q shows the oldest one.
  logic [N-1:0] mq[$];
  logic [N-1:0] m_last;
  logic [31:0]  m_stall;
  bit           seen_reset = 0;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_last     = '0;
      m_stall    = '0;
      seen_reset = 1;
    end else if (seen_reset) begin
      automatic bit pop  = (mq.size() > 0) && bus.out_ready;
      automatic bit push = bus.in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !bus.out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (bus.flush) begin
        mq.delete();
        m_last = '0;
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(bus.d);
        if (mq.size() > 0) m_last = mq[0];
      end
    end
  end

  always @(negedge clk) begin
    if (seen_reset) begin
      chk("model_q_valid",  N'(bus.q_valid),  N'(mq.size() > 0));
      chk("model_in_ready", N'(bus.in_ready), N'(mq.size() < 2));
      chk("model_q",        bus.q,            m_last);
`ifdef PIPE_SKID_STATS_EN
      chk("model_stall",    N'(stall_count),  N'(m_stall));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] dv, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.d         = dv;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  logic [1:0] pat [24] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01,
                           2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11,
                           2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11};

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    chk("rst_q",        bus.q,            '0);
    chk("rst_q_valid",  N'(bus.q_valid),  '0);
    chk("rst_in_ready", N'(bus.in_ready), N'(1));
`ifdef PIPE_SKID_STATS_EN
    chk("rst_stall",    N'(stall_count),  '0);
`endif

    // Streaming at full rate
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, N'(i), 1'b1, 1'b0);
      step();
      chk("stream_q",        bus.q,            N'(i));
      chk("stream_q_valid",  N'(bus.q_valid),  N'(1));
      chk("stream_in_ready", N'(bus.in_ready), N'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("drain_q_valid", N'(bus.q_valid), '0);

    // Backpressure fills the skid entry
    drive(1'b1, N'(5), 1'b0, 1'b0);
    step();
    chk("bp_q5", bus.q, N'(5));
    drive(1'b1, N'(6), 1'b0, 1'b0);
    step();
    chk("bp_full_in_ready", N'(bus.in_ready), '0);
    chk("bp_full_q",        bus.q,            N'(5));
    drive(1'b1, N'(7), 1'b0, 1'b0);
    step();
    chk("bp_hold_q",        bus.q,            N'(5));
    chk("bp_hold_in_ready", N'(bus.in_ready), '0);
    drive(1'b1, N'(7), 1'b1, 1'b0);
    step();
    chk("bp_q6", bus.q, N'(6));
    step();
    chk("bp_q7", bus.q, N'(7));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("bp_empty", N'(bus.q_valid), '0);

    // Mixed handshake pattern checked by the model
    for (int i = 0; i < 24; i++) begin
      drive(pat[i][1], N'(100 + i), pat[i][0], 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    chk("mix_drained", N'(bus.q_valid), '0);

    // Flush from FULL beats simultaneous in/out transfers
    drive(1'b1, N'(8), 1'b0, 1'b0);
    step();
    drive(1'b1, N'(9), 1'b0, 1'b0);
    step();
    chk("fl_full", N'(bus.in_ready), '0);
    drive(1'b1, N'(10), 1'b1, 1'b1);
    step();
    chk("fl_q_valid",  N'(bus.q_valid),  '0);
    chk("fl_q",        bus.q,            '0);
    chk("fl_in_ready", N'(bus.in_ready), N'(1));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("fl_no10", N'(bus.q_valid), '0);

    // Reset mid-operation
    drive(1'b1, N'(11), 1'b0, 1'b0);
    step();
    chk("rb_busy_q", bus.q, N'(11));
    reset = 1'b0;
    drive(1'b1, N'(12), 1'b0, 1'b0);
    step();
    chk("rb_q",       bus.q,           '0);
    chk("rb_q_valid", N'(bus.q_valid), '0);
    reset = 1'b1;
    drive(1'b1, N'(13), 1'b1, 1'b0);
    step();
    chk("rb_first_q", bus.q, N'(13));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

`ifdef PIPE_SKID_STATS_EN
    chk("st_zero", N'(stall_count), '0);
    drive(1'b1, N'(20), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (7) step();
    chk("st_seven", N'(stall_count), N'(7));
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    chk("st_after_flush", N'(stall_count), N'(7));
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    chk("st_idle", N'(stall_count), N'(7));
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
